// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader and the
// fetch/decode datapath that reads the memory it fills.
package loader_pkg;

    localparam int WORD_W = 16;
    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        CNT_H,
        CNT_L,
        DAT_H,
        DAT_L,
        CSUM,
        DONE,
        ERR
    } state_t;

    // Running 8-bit checksum, wraps mod 256.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Boot-time program loader: framed byte stream -> big-endian 16-bit words in
// instruction memory from address 0. Define PROG_LOADER_CSUM_EN for the trailing checksum byte.
module prog_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W = 12,
    parameter logic [7:0] HDR    = HDR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    // Largest legal word count is the full memory depth.
    localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

    state_t            state;
    logic [7:0]        cnt_hi;
    logic [7:0]        dat_hi;
    logic [15:0]       n_words;
    logic [ADDR_W-1:0] addr;
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0]        csum;
`endif

    logic        accept;
    logic [15:0] n_next;
    logic [16:0] wl_next;
    logic        last_word;

    assign accept    = rx_valid && rx_ready;
    assign n_next    = {cnt_hi, rx_data};
    assign wl_next   = 17'(words_loaded) + 17'd1;
    assign last_word = (wl_next == {1'b0, n_words});

    // Byte holding registers carry no reset; they are only read after being written.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (state == CNT_H) cnt_hi <= rx_data;
            if (state == CNT_L) n_words <= n_next;
            if (state == DAT_H) dat_hi <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rx_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            addr         <= '0;
`ifdef PROG_LOADER_CSUM_EN
            csum         <= '0;
`endif
        end else begin
            rx_ready <= 1'b1;
            imem_we  <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE, DONE, ERR: begin
                        // A header restarts a load from any resting state.
                        if (rx_data == HDR) begin
                            state        <= CNT_H;
                            cpu_hold     <= 1'b1;
                            done         <= 1'b0;
                            err          <= 1'b0;
                            words_loaded <= '0;
                            addr         <= '0;
`ifdef PROG_LOADER_CSUM_EN
                            csum         <= '0;
`endif
                        end
                    end
                    CNT_H: begin
                        state <= CNT_L;
`ifdef PROG_LOADER_CSUM_EN
                        csum  <= csum_add(csum, rx_data);
`endif
                    end
                    CNT_L: begin
`ifdef PROG_LOADER_CSUM_EN
                        csum <= csum_add(csum, rx_data);
`endif
                        if ({1'b0, n_next} > MAX_N) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else if (n_next == 16'd0) begin
`ifdef PROG_LOADER_CSUM_EN
                            state <= CSUM;
`else
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else begin
                            state <= DAT_H;
                        end
                    end
                    DAT_H: begin
                        state <= DAT_L;
`ifdef PROG_LOADER_CSUM_EN
                        csum  <= csum_add(csum, rx_data);
`endif
                    end
                    DAT_L: begin
                        imem_we      <= 1'b1;
                        imem_addr    <= addr;
                        imem_wdata   <= {dat_hi, rx_data};
                        addr         <= addr + 1'b1;
                        words_loaded <= wl_next[ADDR_W:0];
`ifdef PROG_LOADER_CSUM_EN
                        csum         <= csum_add(csum, rx_data);
`endif
                        if (last_word) begin
`ifdef PROG_LOADER_CSUM_EN
                            state <= CSUM;
`else
                            // Final write and hold release land in the same cycle.
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else begin
                            state <= DAT_H;
                        end
                    end
`ifdef PROG_LOADER_CSUM_EN
                    CSUM: begin
                        if (rx_data == csum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a 16-word memory (ADDR_W=4); follows
// the PROG_LOADER_CSUM_EN setting of the build.
module tb_prog_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0]   mem [16];
    int            wr_cnt = 0;
    logic [AW-1:0] last_addr;

    prog_loader #(.ADDR_W(AW), .HDR(8'hA5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Memory model fed by the write port.
    always @(posedge clk) begin
        if (imem_we) begin
            mem[imem_addr] <= imem_wdata;
            last_addr      <= imem_addr;
            wr_cnt         <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, ".we"},       {31'd0, imem_we},  32'd0);
        check({tag, ".addr"},     32'(imem_addr),    32'd0);
        check({tag, ".wdata"},    32'(imem_wdata),   32'd0);
        check({tag, ".hold"},     {31'd0, cpu_hold}, 32'd1);
        check({tag, ".done"},     {31'd0, done},     32'd0);
        check({tag, ".err"},      {31'd0, err},      32'd0);
        check({tag, ".wl"},       32'(words_loaded), 32'd0);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'd0, rx_ready}, 32'd1);

        // Noise then a zero-length frame.
        send(8'h00); send(8'hFF);
        check("noise_ignored_hold", {31'd0, cpu_hold}, 32'd1);
        send(8'hA5); send(8'h00); send(8'h00);
`ifdef PROG_LOADER_CSUM_EN
        send(8'h00);
`endif
        check("zero.done", {31'd0, done},     32'd1);
        check("zero.hold", {31'd0, cpu_hold}, 32'd0);
        check("zero.wl",   32'(words_loaded), 32'd0);
        check("zero.writes", 32'(wr_cnt),     32'd0);

        // Basic two-word load; restart from DONE.
        send(8'hA5);
        check("restart.hold", {31'd0, cpu_hold}, 32'd1);
        check("restart.done", {31'd0, done},     32'd0);
        send(8'h00); send(8'h02); send(8'h12); send(8'h34);
        check("w0.we",   {31'd0, imem_we},   32'd1);
        check("w0.addr", 32'(imem_addr),     32'd0);
        check("w0.data", 32'(imem_wdata),    32'h1234);
        send(8'hAB);
        check("w0.we_one_cycle", {31'd0, imem_we}, 32'd0);
        send(8'hCD);
        check("w1.addr", 32'(imem_addr),  32'd1);
        check("w1.data", 32'(imem_wdata), 32'hABCD);
`ifdef PROG_LOADER_CSUM_EN
        check("basic.hold_before_csum", {31'd0, cpu_hold}, 32'd1);
        send(8'hC0);
`endif
        check("basic.done", {31'd0, done},     32'd1);
        check("basic.hold", {31'd0, cpu_hold}, 32'd0);
        check("basic.err",  {31'd0, err},      32'd0);
        check("basic.wl",   32'(words_loaded), 32'd2);
        @(posedge clk); #1;
        check("basic.mem0", 32'(mem[0]), 32'h1234);
        check("basic.mem1", 32'(mem[1]), 32'hABCD);
        check("basic.writes", 32'(wr_cnt), 32'd2);

        // Second program overwrites from address 0.
        send(8'hA5);
        check("restart2.hold", {31'd0, cpu_hold}, 32'd1);
        check("restart2.done", {31'd0, done},     32'd0);
        send(8'h00); send(8'h01); send(8'hBE); send(8'hEF);
`ifdef PROG_LOADER_CSUM_EN
        send(8'hAE);
`endif
        check("beef.done", {31'd0, done}, 32'd1);
        check("beef.wl",   32'(words_loaded), 32'd1);
        @(posedge clk); #1;
        check("beef.mem0", 32'(mem[0]), 32'hBEEF);
        check("beef.mem1_kept", 32'(mem[1]), 32'hABCD);

`ifdef PROG_LOADER_CSUM_EN
        // Bad checksum: words stay written, core stays held.
        w0 = wr_cnt;
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
        send(8'hC1);
        check("badcs.err",  {31'd0, err},      32'd1);
        check("badcs.done", {31'd0, done},     32'd0);
        check("badcs.hold", {31'd0, cpu_hold}, 32'd1);
        @(posedge clk); #1;
        check("badcs.writes", 32'(wr_cnt - w0), 32'd2);
`endif

        // Count overflow: 17 words into a 16-word memory.
        w0 = wr_cnt;
        send(8'hA5); send(8'h00);
        check("ovf.err_before", {31'd0, err}, 32'd0);
        send(8'h11);
        check("ovf.err",  {31'd0, err},      32'd1);
        check("ovf.hold", {31'd0, cpu_hold}, 32'd1);
        send(8'h10); send(8'h00);
        @(posedge clk); #1;
        check("ovf.writes", 32'(wr_cnt - w0), 32'd0);

        // Full memory: 16 words, last address 15.
        w0 = wr_cnt;
        send(8'hA5); send(8'h00); send(8'h10);
        for (int i = 0; i < 16; i++) begin
            send(8'h10);
            send(8'(i));
        end
`ifdef PROG_LOADER_CSUM_EN
        send(8'h88);
`endif
        check("full.done", {31'd0, done},     32'd1);
        check("full.err",  {31'd0, err},      32'd0);
        check("full.wl",   32'(words_loaded), 32'd16);
        @(posedge clk); #1;
        check("full.writes",    32'(wr_cnt - w0), 32'd16);
        check("full.last_addr", 32'(last_addr),   32'd15);
        check("full.mem15",     32'(mem[15]),     32'h100F);

        // Reset mid-frame, then a clean frame.
        send(8'hA5); send(8'h00); send(8'h02); send(8'h12);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        send(8'hA5); send(8'h00); send(8'h01); send(8'h55); send(8'h66);
`ifdef PROG_LOADER_CSUM_EN
        send(8'hBC);
`endif
        check("after_rst.done", {31'd0, done},     32'd1);
        check("after_rst.hold", {31'd0, cpu_hold}, 32'd0);
        @(posedge clk); #1;
        check("after_rst.mem0", 32'(mem[0]), 32'h5566);
        check("after_rst.mem1_kept", 32'(mem[1]), 32'h1001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
